// File: rtl/force_release_seq_pkg.sv
// Shared types for the force/release sequencer: FSM states, per-state
// compare-target selection and a small helper that maps one to the other.
package force_release_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FORCE,
    ST_RELEASE,
    ST_GAP,
    ST_DONE
  } fr_state_e;

  // What i_net is compared against in a given state.
  localparam logic [1:0] CHK_NONE   = 2'd0;
  localparam logic [1:0] CHK_FORCED = 2'd1;
  localparam logic [1:0] CHK_DRIVER = 2'd2;

  // Compare target per state; the settle mask is applied by the caller.
  function automatic logic [1:0] chk_mode(input fr_state_e st);
    case (st)
      ST_FORCE: return CHK_FORCED;
      ST_GAP:   return CHK_DRIVER;
      default:  return CHK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/force_release_seq_if.sv
// Bus between the sequencer and its environment (target net + controller).
//   i_start/i_value : run request and iteration-0 force value
//   i_net/i_drv     : observed forced net and its normal driver value
//   o_*             : force/release controls, status and pass counter
// master = sequencer side, slave = environment side.
interface force_release_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic             i_start;
  logic             i_value;
  logic             i_net;
  logic             i_drv;
  logic             o_force;
  logic             o_force_value;
  logic             o_release;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic [CNT_W-1:0] o_pass_cnt;

  modport master (
    input  i_start, i_value, i_net, i_drv,
    output o_force, o_force_value, o_release, o_busy, o_done, o_err, o_pass_cnt
  );

  modport slave (
    output i_start, i_value, i_net, i_drv,
    input  o_force, o_force_value, o_release, o_busy, o_done, o_err, o_pass_cnt
  );
endinterface

// File: rtl/force_release_seq_len_timer.sv
// Loadable down-counter used to time both the FORCE and GAP phases.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : load i_load_val (phase length minus one)
//   o_last_c       : counter has reached zero (last cycle of the phase)
//   o_first_c      : first cycle after a load (settle-mask window)
module fr_len_timer #(
  parameter int unsigned W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_last_c,
  output logic         o_first_c
);

  logic [W-1:0] cnt_q;
  logic         first_q;

  // Count down to zero and hold; a load restarts the phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else if (i_load) begin
      cnt_q   <= i_load_val;
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end
  end

  assign o_last_c  = (cnt_q == '0);
  assign o_first_c = first_q;

endmodule

// File: rtl/force_release_seq.sv
// Force/release stimulus-and-check sequencer. On an accepted start it runs
// ITERS iterations of FORCE (FORCE_LEN cycles), RELEASE (1 cycle) and
// GAP (GAP_LEN cycles), toggling the force value each iteration, checks the
// observed net against the forced value / normal driver and counts clean
// iterations.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : force_release_seq_if master (requests in, controls and
//                    status out, all outputs registered)
module force_release_seq
  import force_release_pkg::*;
#(
  parameter int unsigned FORCE_LEN = 4,
  parameter int unsigned GAP_LEN   = 3,
  parameter int unsigned ITERS     = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  force_release_seq_if.master   bus
);

  localparam int unsigned MAX_LEN = (FORCE_LEN > GAP_LEN) ? FORCE_LEN : GAP_LEN;
  localparam int unsigned TMR_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W   = (ITERS > 1) ? $clog2(ITERS) : 1;

  fr_state_e        state_q;
  logic             force_q;
  logic             force_value_q;
  logic             release_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             iter_err_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] pass_q;

  logic             tmr_load_c;
  logic [TMR_W-1:0] tmr_val_c;
  logic             tmr_last_c;
  logic             tmr_first_c;
  logic             more_iters_c;
  logic [1:0]       chk_c;
  logic             mismatch_c;

  fr_len_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load_c),
    .i_load_val (tmr_val_c),
    .o_last_c   (tmr_last_c),
    .o_first_c  (tmr_first_c)
  );

  assign more_iters_c = (idx_q < IDX_W'(ITERS - 1));

  // Timer loads on entry to FORCE (from IDLE or GAP) and on entry to GAP.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = TMR_W'(FORCE_LEN - 1);
    case (state_q)
      ST_IDLE:    tmr_load_c = bus.i_start;
      ST_RELEASE: begin
        tmr_load_c = 1'b1;
        tmr_val_c  = TMR_W'(GAP_LEN - 1);
      end
      ST_GAP:     tmr_load_c = tmr_last_c && more_iters_c;
      default:    ;
    endcase
  end

  // Net check; the first cycle of each phase is masked to let the net settle.
  always_comb begin
    chk_c      = tmr_first_c ? CHK_NONE : chk_mode(state_q);
    mismatch_c = 1'b0;
    case (chk_c)
      CHK_FORCED: mismatch_c = (bus.i_net != force_value_q);
      CHK_DRIVER: mismatch_c = (bus.i_net != bus.i_drv);
      default:    mismatch_c = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs, iteration index and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      force_q       <= 1'b0;
      force_value_q <= 1'b0;
      release_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      iter_err_q    <= 1'b0;
      idx_q         <= '0;
      pass_q        <= '0;
    end else begin
      release_q <= 1'b0;
      done_q    <= 1'b0;
      if (mismatch_c) begin
        err_q      <= 1'b1;
        iter_err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            state_q       <= ST_FORCE;
            force_q       <= 1'b1;
            busy_q        <= 1'b1;
            force_value_q <= bus.i_value;
            err_q         <= 1'b0;
            iter_err_q    <= 1'b0;
            idx_q         <= '0;
            pass_q        <= '0;
          end
        end
        ST_FORCE: begin
          if (tmr_last_c) begin
            state_q   <= ST_RELEASE;
            force_q   <= 1'b0;
            release_q <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (tmr_last_c) begin
            // Same-cycle mismatch counts against this iteration.
            if (!(iter_err_q || mismatch_c) && (pass_q != '1)) begin
              pass_q <= pass_q + CNT_W'(1);
            end
            if (more_iters_c) begin
              state_q       <= ST_FORCE;
              force_q       <= 1'b1;
              force_value_q <= ~force_value_q;
              idx_q         <= idx_q + IDX_W'(1);
              iter_err_q    <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_force       = force_q;
  assign bus.o_force_value = force_value_q;
  assign bus.o_release     = release_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;
  assign bus.o_pass_cnt    = pass_q;

endmodule
